stopwatch_cascade_cnt: RTL and testbench

- Parametrised multi-field stopwatch/timer core: prescaler plus cascaded seconds/minutes/hours modulo counters.
- Successor to the single-field divided-clock counter. Adds:
  - pause without losing prescaler phase
  - synchronous clear and preset load
  - count-down mode with sticky done flag
  - lap (display freeze)
  - carry/wrap pulses
- Feeds the 7-segment display driver and the alarm compare logic.

---
 rtl/stopwatch_cascade_cnt.sv | 144 ++++++++++++++
 tb/tb_stopwatch_cascade_cnt.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cascade_cnt.sv
// Stopwatch/timer core: prescaler plus cascaded sec/min/hr modulo counters, up or down.
// Latency: tick/wrap/done and internal fields update on the unit-event edge; sec/min/hr displays follow one edge later.
// Backpressure: none; run=0 pauses and keeps prescaler phase, lap=1 freezes displays, done=1 halts all counting.
// Ports: new_clk/rst (async active-low) | run, clr, load, load_sec/min/hr, down, lap in
//        | sec/min/hr registered displays, tick/wrap one-cycle pulses, done sticky.
module stopwatch_cascade_cnt #(
  parameter int DIV     = 50,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HR_MOD  = 24,
  parameter int W       = 7
) (
  input  logic         new_clk,
  input  logic         rst,
  input  logic         run,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_sec,
  input  logic [W-1:0] load_min,
  input  logic [W-1:0] load_hr,
  input  logic         down,
  input  logic         lap,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hr,
  output logic         tick,
  output logic         wrap,
  output logic         done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [W-1:0]  SEC_LAST = W'(SEC_MOD - 1);
  localparam logic [W-1:0]  MIN_LAST = W'(MIN_MOD - 1);
  localparam logic [W-1:0]  HR_LAST  = W'(HR_MOD - 1);
  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [W-1:0]  ZERO     = '0;

  logic [PW-1:0] presc;
  logic [W-1:0]  sec_f, min_f, hr_f;
  logic [W-1:0]  sec_n, min_n, hr_n;
  logic          unit_ev;
  logic          all_max, all_zero;

  // Preset values above the field range clamp to the field's top value.
  function automatic logic [W-1:0] sat(input logic [W-1:0] v, input logic [W-1:0] last);
    return (v > last) ? last : v;
  endfunction

  assign unit_ev  = run && !done && (presc == PRE_LAST);
  assign all_max  = (sec_f == SEC_LAST) && (min_f == MIN_LAST) && (hr_f == HR_LAST);
  assign all_zero = (sec_f == ZERO) && (min_f == ZERO) && (hr_f == ZERO);

  // Next field values for a unit event, carry/borrow rippling sec -> min -> hr.
  always_comb begin
    sec_n = sec_f;
    min_n = min_f;
    hr_n  = hr_f;
    if (!down) begin
      if (sec_f == SEC_LAST) begin
        sec_n = ZERO;
        if (min_f == MIN_LAST) begin
          min_n = ZERO;
          hr_n  = (hr_f == HR_LAST) ? ZERO : hr_f + ONE;
        end else begin
          min_n = min_f + ONE;
        end
      end else begin
        sec_n = sec_f + ONE;
      end
    end else if (!all_zero) begin
      // With a nonzero total the borrow can only reach hr when hr is nonzero.
      if (sec_f == ZERO) begin
        sec_n = SEC_LAST;
        if (min_f == ZERO) begin
          min_n = MIN_LAST;
          hr_n  = hr_f - ONE;
        end else begin
          min_n = min_f - ONE;
        end
      end else begin
        sec_n = sec_f - ONE;
      end
    end
  end

  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      sec_f <= '0;
      min_f <= '0;
      hr_f  <= '0;
      sec   <= '0;
      min   <= '0;
      hr    <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      // Clear overrides lap: displays are zeroed even while frozen.
      presc <= '0;
      sec_f <= '0;
      min_f <= '0;
      hr_f  <= '0;
      sec   <= '0;
      min   <= '0;
      hr    <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (!lap) begin
        sec <= sec_f;
        min <= min_f;
        hr  <= hr_f;
      end
      if (load) begin
        // Load suppresses any coincident unit event.
        presc <= '0;
        sec_f <= sat(load_sec, SEC_LAST);
        min_f <= sat(load_min, MIN_LAST);
        hr_f  <= sat(load_hr, HR_LAST);
        done  <= 1'b0;
      end else if (unit_ev) begin
        presc <= '0;
        tick  <= 1'b1;
        wrap  <= !down && all_max;
        if (down && all_zero) begin
          done <= 1'b1;
        end
        sec_f <= sec_n;
        min_f <= min_n;
        hr_f  <= hr_n;
      end else if (run && !done) begin
        presc <= presc + PRE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_cascade_cnt.sv
// Directed self-checking bench for stopwatch_cascade_cnt with DIV=4.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench runs a fixed linear sequence and always finishes.
module tb_stopwatch_cascade_cnt;

  localparam int W = 7;

  logic         new_clk = 1'b0;
  logic         rst;
  logic         run, clr, load, down, lap;
  logic [W-1:0] load_sec, load_min, load_hr;
  logic [W-1:0] sec, min, hr;
  logic         tick, wrap, done;

  int checks = 0;
  int errors = 0;

  stopwatch_cascade_cnt #(
    .DIV(4), .SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24), .W(W)
  ) dut (
    .new_clk (new_clk),
    .rst     (rst),
    .run     (run),
    .clr     (clr),
    .load    (load),
    .load_sec(load_sec),
    .load_min(load_min),
    .load_hr (load_hr),
    .down    (down),
    .lap     (lap),
    .sec     (sec),
    .min     (min),
    .hr      (hr),
    .tick    (tick),
    .wrap    (wrap),
    .done    (done)
  );

  always #5 new_clk = ~new_clk;

  task automatic step(input int n);
    repeat (n) @(posedge new_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic set_load(input logic [W-1:0] s, input logic [W-1:0] m, input logic [W-1:0] h);
    load_sec = s;
    load_min = m;
    load_hr  = h;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; clr = 1'b0; load = 1'b0; down = 1'b0; lap = 1'b0;
    set_load(0, 0, 0);

    // Reset state
    #3;
    chk("rst_sec", sec, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    step(1);
    rst = 1'b1;
    run = 1'b1;

    // Up count: tick every 4th edge, displays one edge behind
    step(3);
    chk("up_tick_pre", tick, 0);
    step(1);
    chk("up_tick_first", tick, 1);
    chk("up_sec_lag", sec, 0);
    step(1);
    chk("up_tick_drop", tick, 0);
    chk("up_sec1", sec, 1);
    step(36);
    chk("up_sec10", sec, 10);
    chk("up_min0", min, 0);
    chk("up_hr0", hr, 0);
    chk("up_done0", done, 0);

    // Full wrap from 23:59:59
    set_load(59, 59, 23);
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk("wrap_pre", wrap, 0);
    step(1);
    chk("wrap_pulse", wrap, 1);
    chk("wrap_tick", tick, 1);
    chk("wrap_disp_sec59", sec, 59);
    chk("wrap_disp_hr23", hr, 23);
    step(1);
    chk("wrap_drop", wrap, 0);
    chk("wrap_sec0", sec, 0);
    chk("wrap_min0", min, 0);
    chk("wrap_hr0", hr, 0);
    step(4);
    chk("wrap_cont_sec1", sec, 1);
    chk("wrap_cont_wrap0", wrap, 0);

    // Down count from 0:01:02 to done
    down = 1'b1;
    set_load(2, 1, 0);
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(5);
    chk("dn_sec1", sec, 1);
    chk("dn_min1", min, 1);
    step(8);
    chk("dn_borrow_sec59", sec, 59);
    chk("dn_borrow_min0", min, 0);
    step(240);
    chk("dn_done", done, 1);
    chk("dn_sec0", sec, 0);
    chk("dn_min0", min, 0);
    chk("dn_hr0", hr, 0);
    step(4);
    chk("dn_tick_stopped", tick, 0);
    chk("dn_done_held", done, 1);
    run = 1'b0;
    down = 1'b0;
    step(2);
    chk("dn_done_sticky", done, 1);
    set_load(0, 0, 0);
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("dn_load_clears_done", done, 0);

    // Pause keeps prescaler phase
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    run = 1'b1;
    step(2);
    run = 1'b0;
    step(10);
    chk("pause_no_tick", tick, 0);
    run = 1'b1;
    step(1);
    chk("resume_tick_wait", tick, 0);
    step(1);
    chk("resume_tick", tick, 1);
    step(1);
    chk("resume_sec1", sec, 1);

    // Lap freeze
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(21);
    chk("lap_start_sec5", sec, 5);
    lap = 1'b1;
    step(6);
    chk("lap_hold_mid", sec, 5);
    step(6);
    chk("lap_hold_end", sec, 5);
    lap = 1'b0;
    step(1);
    chk("lap_release_sec8", sec, 8);
    lap = 1'b1;
    clr = 1'b1;
    step(1);
    chk("lap_clr_sec0", sec, 0);
    chk("lap_clr_tick0", tick, 0);
    clr = 1'b0;
    lap = 1'b0;

    // clr beats load
    run = 1'b0;
    set_load(30, 20, 5);
    clr = 1'b1;
    load = 1'b1;
    step(1);
    clr = 1'b0;
    load = 1'b0;
    step(1);
    chk("clr_load_sec", sec, 0);
    chk("clr_load_min", min, 0);
    chk("clr_load_hr", hr, 0);

    // Saturating preset
    set_load(70, 61, 30);
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk("sat_sec59", sec, 59);
    chk("sat_min59", min, 59);
    chk("sat_hr23", hr, 23);

    // load beats a coincident unit event
    set_load(10, 0, 0);
    load = 1'b1;
    step(1);
    load = 1'b0;
    run = 1'b1;
    step(3);
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("load_win_tick0", tick, 0);
    step(1);
    chk("load_win_sec10", sec, 10);
    chk("load_win_tick_still0", tick, 0);

    // Asynchronous reset between edges
    step(8);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_sec", sec, 0);
    chk("arst_min", min, 0);
    chk("arst_hr", hr, 0);
    chk("arst_tick", tick, 0);
    chk("arst_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
